// File: rtl/wr_arb_pkg.sv
// Shared state encoding, widths and helpers for the FIFO write-port arbiter.
package wr_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int unsigned BEAT_TOTAL_W = 16;

  // Increment with wrap at modulus; used to advance the round-robin pointer past the winner.
  function automatic int unsigned wrap_inc(input int unsigned val, input int unsigned modulus);
    return ((val + 1) >= modulus) ? 0 : (val + 1);
  endfunction

endpackage

// File: rtl/wr_port_arbiter_if.sv
// Producer/FIFO-facing bundle of the write-port arbiter; master is the environment, slave the arbiter.
interface wr_port_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  import wr_arb_pkg::*;

  logic                          arb_en;
  logic [NUM_REQ-1:0]            in_valid;
  logic [NUM_REQ-1:0]            in_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]            in_ready;
  logic                          wr_full;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          busy;
  logic [BEAT_TOTAL_W-1:0]       beat_total;

  modport master (
    output arb_en, in_valid, in_last, in_data, wr_full,
    input  in_ready, wr_en, wr_data, gnt, busy, beat_total
  );

  modport slave (
    input  arb_en, in_valid, in_last, in_data, wr_full,
    output in_ready, wr_en, wr_data, gnt, busy, beat_total
  );

endinterface

// File: rtl/wr_port_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests to start at rr_ptr, then take the lowest set bit.
module rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               pick_vld,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [PTR_W-1:0]   pick_idx
);

  logic [NUM_REQ-1:0] rot_c;
  logic [PTR_W-1:0]   off_c;
  logic               found_c;

  always_comb begin
    rot_c   = '0;
    off_c   = '0;
    found_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rot_c[i] = req[PTR_W'((i + 32'(rr_ptr)) % NUM_REQ)];
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found_c && rot_c[i]) begin
        off_c   = PTR_W'(i);
        found_c = 1'b1;
      end
    end
    pick_vld = found_c;
    pick_idx = PTR_W'((32'(rr_ptr) + 32'(off_c)) % NUM_REQ);
    pick_oh  = '0;
    if (found_c) pick_oh[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/wr_port_arbiter.sv
// Round-robin, packet-locked arbiter sharing one async-FIFO write port among NUM_REQ producers.
module wr_port_arbiter
  import wr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned IDLE_LIMIT = 8
) (
  input logic              wr_clk,
  input logic              wr_rstn,
  wr_port_arbiter_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(NUM_REQ);
  localparam int unsigned BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned IDLE_W = $clog2(IDLE_LIMIT + 1);

  logic [0:0]              state_q, state_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [PTR_W-1:0]        gnt_idx_q, gnt_idx_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic [BEAT_TOTAL_W-1:0] beat_total_q, beat_total_d;

  logic                    pick_vld_c;
  logic [NUM_REQ-1:0]      pick_oh_c;
  logic [PTR_W-1:0]        pick_idx_c;

  logic                    in_grant_c;
  logic                    sel_valid_c;
  logic                    sel_last_c;
  logic [DATA_WIDTH-1:0]   sel_data_c;
  logic                    accept_c;
  logic                    idle_tick_c;
  logic                    release_c;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req      (bus.in_valid),
    .rr_ptr   (rr_ptr_q),
    .pick_vld (pick_vld_c),
    .pick_oh  (pick_oh_c),
    .pick_idx (pick_idx_c)
  );

  // Granted requester's view; a full FIFO freezes everything, including the idle timeout.
  always_comb begin
    in_grant_c  = (state_q == ST_GRANT);
    sel_valid_c = bus.in_valid[gnt_idx_q];
    sel_last_c  = bus.in_last[gnt_idx_q];
    sel_data_c  = bus.in_data[32'(gnt_idx_q) * DATA_WIDTH +: DATA_WIDTH];
    accept_c    = in_grant_c & sel_valid_c & ~bus.wr_full;
    idle_tick_c = in_grant_c & ~sel_valid_c & ~bus.wr_full;
    release_c   = (accept_c & (sel_last_c | (beat_cnt_q == BEAT_W'(MAX_BURST - 1))))
                | (idle_tick_c & (idle_cnt_q == IDLE_W'(IDLE_LIMIT - 1)));
  end

  assign bus.in_ready   = (in_grant_c && !bus.wr_full) ? gnt_q : '0;
  assign bus.wr_en      = accept_c;
  assign bus.wr_data    = in_grant_c ? sel_data_c : '0;
  assign bus.gnt        = gnt_q;
  assign bus.busy       = in_grant_c;
  assign bus.beat_total = beat_total_q;

  // Next-state: the IDLE state doubles as the mandatory one-cycle bubble between grants.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gnt_idx_d    = gnt_idx_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    beat_total_d = beat_total_q + BEAT_TOTAL_W'(accept_c);
    case (state_q)
      ST_IDLE: begin
        if (bus.arb_en && pick_vld_c) begin
          state_d   = ST_GRANT;
          gnt_d     = pick_oh_c;
          gnt_idx_d = pick_idx_c;
        end
      end
      ST_GRANT: begin
        if (accept_c) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          idle_cnt_d = '0;
        end else if (idle_tick_c) begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
        if (release_c) begin
          state_d    = ST_IDLE;
          gnt_d      = '0;
          rr_ptr_d   = PTR_W'(wrap_inc(32'(gnt_idx_q), NUM_REQ));
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      gnt_idx_q    <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      beat_total_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_idx_q    <= gnt_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      beat_total_q <= beat_total_d;
    end
  end

endmodule
